// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package display_scan_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Clock cycles spent on one digit slot.
  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_tick.sv
// Slot prescaler: counts 0..TICK_DIV-1, flags the guard window and the slot end.
module scan_tick_gen #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic in_guard
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign slot_end = (cnt == CNT_W'(TICK_DIV - 1));
  assign in_guard = (cnt < CNT_W'(GUARD_CYCLES));

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS hex digits through one external decoder with frame-synchronous loading.
// Optional: define LEADING_ZERO_BLANK_EN to auto-blank leading zeros at commit.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic [3:0]              decoder_in,
  input  logic [6:0]              decoder_out,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_HZ, SCAN_HZ);
  localparam int unsigned DW       = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);

  logic [DW-1:0]         disp_digits;
  logic [DW-1:0]         pend_digits;
  logic [NUM_DIGITS-1:0] disp_blank;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_valid;
  logic [IDX_W-1:0]      idx;
  scan_state_t           state;
  logic                  slot_end;
  logic                  in_guard;
  logic                  frame_end;

  scan_tick_gen #(
    .TICK_DIV    (TICK_DIV),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .slot_end(slot_end),
    .in_guard(in_guard)
  );

  assign frame_end  = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
  assign decoder_in = disp_digits[4*int'(idx) +: 4];

  // Blank mask applied when pending data becomes displayed.
  function automatic logic [NUM_DIGITS-1:0] commit_blank(input logic [DW-1:0] d,
                                                         input logic [NUM_DIGITS-1:0] b);
    logic [NUM_DIGITS-1:0] m;
`ifdef LEADING_ZERO_BLANK_EN
    logic seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'h0) seen = 1'b1;
      m[i] = !seen;
    end
`else
    m = '0;
    if (d != '0) m = '0;
`endif
    return b | m;
  endfunction

  // Pending/displayed buffers; a load on the frame-end cycle waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_digits <= '0;
      pend_digits <= '0;
      disp_blank  <= '1;
      pend_blank  <= '1;
      pend_valid  <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (frame_end && pend_valid) begin
        disp_digits <= pend_digits;
        disp_blank  <= commit_blank(pend_digits, pend_blank);
        pend_valid  <= 1'b0;
        load_ack    <= 1'b1;
      end
      if (load) begin
        pend_digits <= digits_in;
        pend_blank  <= blank_in;
        pend_valid  <= 1'b1;
      end
    end
  end

  // Scan FSM: dark guard window, then the current digit until the slot ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_GUARD;
      idx     <= '0;
      an_out  <= '1;
      seg_out <= SEG_OFF;
    end else begin
      case (state)
        ST_GUARD: begin
          an_out  <= '1;
          seg_out <= SEG_OFF;
          if (!in_guard) begin
            state   <= ST_ON;
            an_out  <= disp_blank[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg_out <= decoder_out;
          end
        end
        ST_ON: begin
          an_out  <= disp_blank[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);
          seg_out <= decoder_out;
          if (slot_end) begin
            state <= ST_GUARD;
            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
          end
        end
        default: begin
          state   <= ST_GUARD;
          an_out  <= '1;
          seg_out <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: expected frames queued at load, checked after each ack.
module tb_display_scan_ctrl;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits_in = '0;
  logic [ND-1:0] blank_in = '0;
  logic          load = 1'b0;
  logic          load_ack;
  logic [3:0]    decoder_in;
  logic [6:0]    decoder_out;
  logic [6:0]    seg_out;
  logic [ND-1:0] an_out;

  typedef struct packed {
    logic [15:0]   d;
    logic [ND-1:0] b;
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .GUARD_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .load       (load),
    .load_ack   (load_ack),
    .decoder_in (decoder_in),
    .decoder_out(decoder_out),
    .seg_out    (seg_out),
    .an_out     (an_out)
  );

  // Reference hex decoder, active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  assign decoder_out = seg7(decoder_in);

  function automatic logic [ND-1:0] eff_blank(input frame_t f);
    logic [ND-1:0] m = f.b;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = ND - 1; i >= 1; i--) begin
      if (f.d[4*i +: 4] != 4'h0) break;
      m[i] = 1'b1;
    end
`endif
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one load strobe; replace models a second load overwriting pending data.
  task automatic load_data(input logic [15:0] d, input logic [ND-1:0] b, input bit replace);
    frame_t f;
    f.d = d;
    f.b = b;
    if (replace && exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(f);
    digits_in = d;
    blank_in  = b;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  // One frame after ack: 2 dark cycles, 8 lit cycles per slot, digit 0 first.
  task automatic check_frame(input frame_t f);
    logic [ND-1:0] eb = eff_blank(f);
    logic [ND-1:0] exp_an;
    int u, s;
    for (int t = 1; t <= 40; t++) begin
      tick();
      u = (t - 1) % 10;
      s = (t - 1) / 10;
      if (u < 2 || eb[s]) exp_an = '1;
      else exp_an = ~(ND'(1) << s);
      check("an_out", 32'(an_out), 32'(exp_an));
      if (exp_an != '1) check("seg_out", 32'(seg_out), 32'(seg7(f.d[4*s +: 4])));
      if (t < 40) check("ack_pulse", 32'(load_ack), 32'd0);
    end
  endtask

  task automatic commit_wait(input bit do_check, output int waited);
    frame_t f;
    waited = 0;
    while (!load_ack && waited < 100) begin
      tick();
      waited++;
    end
    check("ack_seen", 32'(load_ack), 32'd1);
    if (load_ack && exp_q.size() > 0) begin
      f = exp_q.pop_front();
      if (do_check) check_frame(f);
    end
  endtask

  task automatic count_dark(input int n, input string tag);
    int lit = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (an_out != '1 || load_ack) lit++;
    end
    check(tag, 32'(lit), 32'd0);
  endtask

  initial begin
    int w;
    // Reset state and idle display
    repeat (3) tick();
    check("rst_an", 32'(an_out), 32'hF);
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_ack", 32'(load_ack), 32'd0);
    rst = 1'b0;
    count_dark(50, "idle_dark");

    // Basic frame
    load_data(16'h1234, 4'b0000, 1'b0);
    commit_wait(1'b1, w);

    // Two loads in one frame: last wins, one ack
    load_data(16'h1111, 4'b0000, 1'b0);
    tick();
    tick();
    load_data(16'h2222, 4'b0000, 1'b1);
    commit_wait(1'b1, w);
    check("single_ack", 32'(load_ack), 32'd0);

    // Load exactly on the frame-end cycle commits one frame later
    load_data(16'h9876, 4'b0000, 1'b0);
    commit_wait(1'b0, w);
    repeat (39) tick();
    load_data(16'hABCD, 4'b0000, 1'b0);
    check("fe_no_ack", 32'(load_ack), 32'd0);
    commit_wait(1'b1, w);
    check("fe_latency", 32'(w), 32'd40);

    // Per-digit blanking
    load_data(16'h5678, 4'b1010, 1'b0);
    commit_wait(1'b1, w);

    // Leading zeros (blanked only when the feature is built in)
    load_data(16'h0050, 4'b0000, 1'b0);
    commit_wait(1'b1, w);
    load_data(16'h0000, 4'b0000, 1'b0);
    commit_wait(1'b1, w);

    // Mid-slot reset: immediate dark, pending dropped, display stays dark
    load_data(16'hFEDC, 4'b0000, 1'b0);
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    check("mid_rst_an", 32'(an_out), 32'hF);
    check("mid_rst_seg", 32'(seg_out), 32'h7F);
    check("mid_rst_ack", 32'(load_ack), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    count_dark(90, "post_rst_dark");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
